// File: rtl/sim_jtag_driver_if.sv
// Command/response handshake bundle between a harness command source and sim_jtag_driver.
interface sim_jtag_driver_if #(
    parameter int MAX_BITS = 64,
    parameter int LW       = $clog2(MAX_BITS + 1)
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_op;
    logic [LW-1:0]       cmd_len;
    logic [MAX_BITS-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [MAX_BITS-1:0] rsp_data;
    logic                rsp_err;
    logic                rsp_undriven;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_undriven
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_undriven
    );
endinterface

// File: rtl/sim_jtag_driver.sv
// Command-driven JTAG master: RESET / SHIFT_IR / SHIFT_DR / RUN_IDLE / EXIT into TAP pin waveforms.
// Define SIM_JTAG_TDO_CHECK_EN to flag (and zero) shift samples taken while TDO is undriven.
module sim_jtag_driver #(
    parameter int TICK_DELAY = 50,
    parameter int MAX_BITS   = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             init_done,
    sim_jtag_driver_if.slave bus,
    output logic             jtag_TCK,
    output logic             jtag_TMS,
    output logic             jtag_TDI,
    output logic             jtag_TRSTn,
    input  logic             jtag_TDO_data,
    input  logic             jtag_TDO_driven,
    output logic [31:0]      exit
);
    localparam int LW = $clog2(MAX_BITS + 1);
    localparam int CW = (LW > 3) ? LW : 3;
    localparam int TW = (TICK_DELAY > 1) ? $clog2(TICK_DELAY) : 1;
    localparam int EW = (MAX_BITS < 31) ? MAX_BITS : 31;

    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RESP, HALT} state_t;
    typedef enum logic [2:0] {
        OP_RESET    = 3'd0,
        OP_SHIFT_IR = 3'd1,
        OP_SHIFT_DR = 3'd2,
        OP_RUN_IDLE = 3'd3,
        OP_EXIT     = 3'd4
    } op_t;

    state_t              state;
    logic [TW-1:0]       tick;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       slen;
    logic [5:0]          pat;
    logic                is_rst;
    logic [MAX_BITS-1:0] sh;
    logic [MAX_BITS-1:0] mask;
    logic [MAX_BITS-1:0] cap;
    logic                err;
    logic                undriven;
    logic                rsp_valid;
    logic [30:0]         code;
    logic                tdo_bit;
    logic                tdo_miss;

`ifdef SIM_JTAG_TDO_CHECK_EN
    assign tdo_bit  = jtag_TDO_driven & jtag_TDO_data;
    assign tdo_miss = ~jtag_TDO_driven;
`else
    logic unused_tdo_driven;
    assign unused_tdo_driven = jtag_TDO_driven;
    assign tdo_bit  = jtag_TDO_data;
    assign tdo_miss = 1'b0;
`endif

    always_comb begin
        code         = '0;
        code[EW-1:0] = bus.cmd_data[EW-1:0];
    end

    logic len_ok, len_nz, last_tick, rise, fall;
    assign len_ok    = bus.cmd_len <= LW'(MAX_BITS);
    assign len_nz    = bus.cmd_len != '0;
    assign last_tick = tick == TW'(TICK_DELAY - 1);
    assign rise      = last_tick && !jtag_TCK;
    assign fall      = last_tick && jtag_TCK;

    assign bus.cmd_ready    = (state == IDLE) && enable && init_done && !reset;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_data     = cap;
    assign bus.rsp_err      = err;
    assign bus.rsp_undriven = undriven;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tick       <= '0;
            cnt        <= '0;
            slen       <= '0;
            pat        <= '0;
            is_rst     <= 1'b0;
            sh         <= '0;
            mask       <= '0;
            cap        <= '0;
            err        <= 1'b0;
            undriven   <= 1'b0;
            rsp_valid  <= 1'b0;
            jtag_TCK   <= 1'b0;
            jtag_TMS   <= 1'b1;
            jtag_TDI   <= 1'b0;
            jtag_TRSTn <= 1'b1;
            exit       <= '0;
        end else if (enable) begin
            case (state)
                IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
                    tick     <= '0;
                    cap      <= '0;
                    err      <= 1'b0;
                    undriven <= 1'b0;
                    is_rst   <= 1'b0;
                    sh       <= bus.cmd_data;
                    slen     <= CW'(bus.cmd_len);
                    jtag_TDI <= 1'b0;
                    case (op_t'(bus.cmd_op))
                        OP_RESET: begin
                            state      <= PRE;
                            pat        <= 6'b011111;
                            cnt        <= CW'(6);
                            is_rst     <= 1'b1;
                            jtag_TMS   <= 1'b1;
                            jtag_TRSTn <= 1'b0;
                        end
                        OP_SHIFT_IR, OP_SHIFT_DR: begin
                            if (len_nz && len_ok) begin
                                state    <= PRE;
                                jtag_TMS <= 1'b1;
                                pat      <= (bus.cmd_op == OP_SHIFT_IR) ? 6'b000011 : 6'b000001;
                                cnt      <= (bus.cmd_op == OP_SHIFT_IR) ? CW'(4) : CW'(3);
                            end else begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                err       <= 1'b1;
                            end
                        end
                        OP_RUN_IDLE: begin
                            if (!len_ok) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                err       <= 1'b1;
                            end else if (!len_nz) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                            end else begin
                                state    <= POST;
                                pat      <= '0;
                                cnt      <= CW'(bus.cmd_len);
                                jtag_TMS <= 1'b0;
                            end
                        end
                        OP_EXIT: begin
                            exit  <= {code, 1'b1};
                            state <= HALT;
                        end
                        default: begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            err       <= 1'b1;
                        end
                    endcase
                end
                PRE, SHIFT, POST: begin
                    tick <= last_tick ? '0 : tick + 1'b1;
                    if (last_tick) jtag_TCK <= !jtag_TCK;
                    if (rise && state == SHIFT) begin
                        cap      <= cap | (mask & {MAX_BITS{tdo_bit}});
                        undriven <= undriven | tdo_miss;
                    end
                    // TMS/TDI for the next TCK are loaded on the falling edge so they
                    // are valid for the whole following low phase.
                    if (fall) begin
                        case (state)
                            PRE: begin
                                if (cnt == CW'(1)) begin
                                    if (is_rst) begin
                                        state     <= RESP;
                                        rsp_valid <= 1'b1;
                                    end else begin
                                        state    <= SHIFT;
                                        cnt      <= slen;
                                        mask     <= MAX_BITS'(1);
                                        jtag_TMS <= (slen == CW'(1));
                                        jtag_TDI <= sh[0];
                                        sh       <= sh >> 1;
                                    end
                                end else begin
                                    cnt        <= cnt - 1'b1;
                                    pat        <= pat >> 1;
                                    jtag_TMS   <= pat[1];
                                    jtag_TRSTn <= !(is_rst && cnt > CW'(2));
                                end
                            end
                            SHIFT: begin
                                if (cnt == CW'(1)) begin
                                    state    <= POST;
                                    cnt      <= CW'(2);
                                    pat      <= 6'b000001;
                                    jtag_TMS <= 1'b1;
                                    jtag_TDI <= 1'b0;
                                end else begin
                                    cnt      <= cnt - 1'b1;
                                    mask     <= mask << 1;
                                    jtag_TMS <= (cnt == CW'(2));
                                    jtag_TDI <= sh[0];
                                    sh       <= sh >> 1;
                                end
                            end
                            default: begin
                                if (cnt == CW'(1)) begin
                                    state     <= RESP;
                                    rsp_valid <= 1'b1;
                                end else begin
                                    cnt      <= cnt - 1'b1;
                                    pat      <= pat >> 1;
                                    jtag_TMS <= pat[1];
                                end
                            end
                        endcase
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sim_jtag_driver.md
# sim_jtag_driver

Synthesizable, command-driven JTAG master for the test harness: it turns queued IR/DR scan, reset, idle and exit commands into TCK/TMS/TDI/TRSTn waveforms and returns captured TDO bits. It generalises the bit-bang simulation driver with a programmable TCK rate, a scan length set at elaboration, a full TAP walk sequencer and a valid/ready command/response path. It sits between a harness-side command source (a ROM, a scripted stimulus or a host bridge) and the DUT's debug TAP, and reports end of test through the same `exit` convention.

## Interface
- `TICK_DELAY`, 50: TCK half-period in `clock` cycles; legal range ≥1.
- `MAX_BITS`, 64: maximum scan length; `LW = $clog2(MAX_BITS+1)`.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, the engine holds its current phase and does not accept commands.
- `init_done` in 1: commands are accepted only when both `enable` and `init_done` are high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: 0 RESET, 1 SHIFT_IR, 2 SHIFT_DR, 3 RUN_IDLE, 4 EXIT; 5–7 are illegal.
- `cmd_len` in LW: number of bits to shift, or the idle TCK count for RUN_IDLE.
- `cmd_data` in MAX_BITS: TDI bits, LSB shifted first; `[30:0]` carries the exit code for EXIT.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out MAX_BITS: captured TDO bits, LSB first; bits at and above `len` are 0.
- `rsp_err` out 1: the command was illegal and no TCK activity occurred.
- `rsp_undriven` out 1: TDO was undriven on at least one sampled shift bit.
- `jtag_TCK`, `jtag_TMS`, `jtag_TDI`, `jtag_TRSTn` out 1 each: JTAG pins.
- `jtag_TDO_data`, `jtag_TDO_driven` in 1 each: TDO pin and its drive-enable.
- `exit` out 32: 0 while running; `{code[30:0],1'b1}` once EXIT executes.

## Operation
- FSM states: IDLE, PRE, SHIFT, POST, RESP, HALT.
- `cmd_ready = (state==IDLE) && enable && init_done && !reset`.
- All register updates occur only when `enable` is high. When `enable` is low, the tick counter, TCK and the FSM freeze and the pins hold their values.
- Each TCK period lasts `2*TICK_DELAY` clocks: TCK is low for TICK_DELAY clocks, then high for TICK_DELAY clocks. TMS/TDI change only at the start of the low phase.
- TDO is sampled on the clock where TCK goes from 0 to 1, using the values present in the last low-phase cycle.
- The TAP is assumed to be in Run-Test/Idle at the start of every command except RESET. Every sequence ends in Run-Test/Idle.
- **RESET:**
  - TMS sequence `1,1,1,1,1,0` (6 TCKs).
  - `jtag_TRSTn` is 0 during the first 5 TCK periods.
  - `cmd_len` is ignored.
- **SHIFT_IR:**
  - PRE sends TMS `1,1,0,0`.
  - SHIFT runs `len` bits with TCK `i` carrying TDI=`cmd_data[i]`. TMS is 0 except on the last bit, where it is 1.
  - POST sends TMS `1,0`.
  - Total TCKs = len+6.
- **SHIFT_DR:** same as SHIFT_IR, but PRE sends TMS `1,0,0`. Total TCKs = len+5.
- **RUN_IDLE:** `len` TCKs with TMS=0. `len=0` is legal and produces zero TCKs.
- **EXIT:**
  - No TCK activity.
  - `exit <= {cmd_data[30:0],1'b1}`, then the FSM enters HALT.
  - HALT is sticky until `reset`; `cmd_ready` stays 0 and no response is produced.
- **Illegal commands:** op 5–7, a shift with `len==0`, or any `len>MAX_BITS`.
  - No TCK activity.
  - A response is returned with `rsp_err=1`, `rsp_data=0`, `rsp_undriven=0`.
- Every non-EXIT command produces exactly one response. `rsp_data` is 0 for RESET and RUN_IDLE.
- RESP holds `rsp_*` stable until `rsp_valid && rsp_ready`; the FSM then returns to IDLE in the same cycle as the handshake.
- **Reset values:** `jtag_TCK=0`, `jtag_TMS=1`, `jtag_TDI=0`, `jtag_TRSTn=1`, `cmd_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `rsp_undriven=0`, `exit=0`, state IDLE.
- Reset asserted mid-scan forces all outputs to their reset values on the next edge. No response is emitted for the aborted command.

## Timing
- Command accepted at cycle t. The first TCK low phase starts at t+1 with TMS/TDI valid.
- `rsp_valid` rises at `t+1+N*2*TICK_DELAY`, where N is the TCK count. TCK is 0 at that point.
- Illegal commands: `rsp_valid` at t+1.
- EXIT: `exit` is updated at t+1.
- Back-to-back throughput: if `rsp_ready` is held at 1, the next command can be accepted in the cycle after the response handshake.
- Cycles with `enable` low add exactly their count to every latency above.

## Configuration
- `SIM_JTAG_TDO_CHECK_EN` defined:
  - On each SHIFT-state sample, `rsp_undriven |= !jtag_TDO_driven`.
  - An undriven sample captures 0.
- Macro undefined:
  - `rsp_undriven` is tied to 0.
  - `jtag_TDO_driven` is ignored, and `jtag_TDO_data` is captured as-is.

## Test plan
- **Reset:** TICK_DELAY=2, RESET command → 6 TCK periods of 4 clocks each. TMS is 1,1,1,1,1,0; TRSTn is low for the first 20 clocks. `rsp_valid` at t+25 with `rsp_data=0`.
- **IR scan:** SHIFT_IR, len=5, data=5'b10110, TDO model returning 5'b00001 → TMS pattern 1,1,0,0,0,0,0,0,1,1,0. TDI bits are 0,1,1,0,1. `rsp_data=1`, `rsp_valid` at t+1+11*4.
- **DR scan at full length:** SHIFT_DR, len=MAX_BITS=64, data=64'hDEADBEEF_01234567, loopback TDO delayed by one TCK → `rsp_data` is the data shifted left by one bit, with the TAP bypass bit as bit 0.
- **Illegal commands:** len=0 SHIFT_DR; op=6; len=65 → each gives `rsp_err=1` at t+1 with no TCK edge.
- **Stall and backpressure:** `enable` dropped for 7 cycles mid-shift, and `rsp_ready` held low for 3 cycles → TCK freezes for those cycles and the latency grows by 7. `rsp_*` stays stable until the handshake.
- **Exit and undriven TDO:** EXIT with code 3 → `exit=32'h7`, and `cmd_ready` stays 0 until reset. With `SIM_JTAG_TDO_CHECK_EN`, a DR scan with `jtag_TDO_driven=0` on bit 2 → `rsp_undriven=1`.
